// File: rtl/imem_loader_if.sv
// imem_loader_if: bundle of the loader's host-side and memory-side signals.
//   master modport: the host/debug byte source.
//     Drives start, base_addr, word_count, in_data and in_valid.
//     Observes in_ready, mem_we, mem_addr, mem_wdata, busy, done and error.
//   slave modport: the loader itself, which sees the same signals with the
//     directions reversed.
//   Parameters:
//     WORD_W  instruction word width, in bits.
//     ADDR_W  word address width.
interface imem_loader_if #(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, base_addr, word_count, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );

  modport slave (
    input  start, base_addr, word_count, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into WORD_W-bit instruction words and
// writes them at consecutive addresses into the instruction memory.
//
// Ports:
//   clk  single clock; all logic runs on the rising edge.
//   rst  synchronous, active-high reset.
//   bus  imem_loader_if.slave, carrying the following signals:
//     start / base_addr / word_count  load request, sampled only in IDLE.
//     in_data / in_valid / in_ready   byte stream handshake.
//                                     The first byte of a word lands in its LSB.
//     mem_we / mem_addr / mem_wdata   one-cycle write per word.
//                                     Address and data hold their values
//                                     between writes.
//     busy                            a load is in progress.
//     done                            one-cycle completion pulse.
//     error                           range error; it stays set until the next
//                                     accepted start.
module imem_loader #(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);
  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = $clog2(BYTES);
  // Memory depth, held at ADDR_W+2 bits so that base+count cannot wrap.
  localparam logic [ADDR_W+1:0] DEPTH = {2'b01, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W:0]     remaining_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [WORD_W-1:0]   word_reg;
  logic [WORD_W-1:0]   word_next;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [WORD_W-1:0]   mem_wdata_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                error_reg;
  logic [ADDR_W+1:0]   end_sum;
  logic                range_bad;

  // Assembled word including the byte on in_data. This lets the last byte go
  // straight into mem_wdata on the edge that enters WRITE.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign word_next[gi*8 +: 8] = (idx_reg == IDX_W'(gi)) ? bus.in_data
                                                          : word_reg[gi*8 +: 8];
  end

  assign end_sum   = {2'b00, bus.base_addr} + {1'b0, bus.word_count};
  assign range_bad = (end_sum > DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      idx_reg       <= '0;
      word_reg      <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      mem_we_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.word_count == '0) begin
              done_reg  <= 1'b1;
              error_reg <= 1'b0;
            end else if (range_bad) begin
              done_reg  <= 1'b1;
              error_reg <= 1'b1;
            end else begin
              error_reg     <= 1'b0;
              addr_reg      <= bus.base_addr;
              remaining_reg <= bus.word_count;
              idx_reg       <= '0;
              busy_reg      <= 1'b1;
              state_reg     <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          // in_ready is high for the whole of COLLECT, so valid alone accepts.
          if (bus.in_valid) begin
            word_reg <= word_next;
            idx_reg  <= idx_reg + 1'b1;
            if (idx_reg == IDX_W'(BYTES - 1)) begin
              state_reg     <= S_WRITE;
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= addr_reg;
              mem_wdata_reg <= word_next;
            end
          end
        end
        S_WRITE: begin
          addr_reg      <= addr_reg + 1'b1;
          remaining_reg <= remaining_reg - 1'b1;
          idx_reg       <= '0;
          if (remaining_reg == (ADDR_W+1)'(1)) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= S_COLLECT;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == S_COLLECT);
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.error     = error_reg;
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the 64-word × 64-bit instruction memory: it writes a program image into the memory. It accepts a byte stream over a valid/ready handshake and packs each run of 8 bytes into one 64-bit instruction word. It then issues a one-cycle write for each word, at consecutive addresses starting from a requested base. It sits between the host/debug byte source and the write port of the instruction memory, and must finish before the fetch path reads the memory.

## Interface
- WORD_W, 64, instruction word width; bytes per word = WORD_W/8 = 8
- ADDR_W, 6, word address width; depth = 2**ADDR_W = 64
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  load request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; sampled with start
- word_count  in  ADDR_W+1  number of words, 0..64; sampled with start
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  WORD_W  write data
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- error  out  1  range error; sticky until the next accepted start or rst

## Operation
- States:
  - IDLE: busy=0, in_ready=0.
  - COLLECT: busy=1, in_ready=1.
  - WRITE: busy=1, in_ready=0, mem_we=1.
- Reset: state IDLE. All outputs 0, and the internal address, remaining-count and byte-index registers are 0.
- Start in IDLE, three outcomes:
  - word_count==0: stay IDLE; next cycle done=1, error=0; no write.
  - base_addr+word_count > 64 (computed at ADDR_W+2 bits, no wrap): stay IDLE; next cycle done=1, error=1; no write.
  - Otherwise: error cleared, addr←base_addr, remaining←word_count, byte index←0, go to COLLECT.
- Start while busy: ignored.
- COLLECT: a byte is accepted on in_valid&in_ready. Byte k of a word (k=0..7) is stored at bits [8k+7:8k], so packing is little-endian and the first byte is the LSB. Acceptance of byte 7 goes to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=addr, mem_wdata=assembled word.
  - Next cycle: addr+1, remaining-1, byte index 0.
  - If remaining was 1: go to IDLE and pulse done. Otherwise go to COLLECT.
- mem_addr and mem_wdata hold their last values while mem_we=0. Only mem_we is qualifying.
- rst mid-load: back to IDLE immediately, the partial word is discarded, no write is issued, and done is not pulsed.
- in_data is ignored whenever in_ready=0.

## Timing
- state, mem_we, done, busy and error are registered. in_ready is decoded from the registered state only, with no combinational path from in_valid.
- Start accepted at cycle T:
  - COLLECT from T+1.
  - With in_valid held high, bytes are accepted at T+1..T+8 and the write occurs at T+9.
- Word n (n=1..N) is written at cycle T+9n; done pulses at T+9N+1, in which busy=0.
- A new start is accepted in the same cycle as done.
- Gaps in in_valid stretch COLLECT; the byte index does not advance on cycles without acceptance.
- The error case has the same done latency as a zero-count load: start at T, done at T+1.

## Test plan
- Single word: base 0, count 1, bytes 0x01..0x08 back-to-back from T+1 -> mem_we only at T+9 with addr 0, data 0x0807060504030201; done at T+10.
- Burst with stalls: base 3, count 3, 24 bytes 0x00..0x17 with in_valid low every third cycle -> writes to addr 3, 4, 5 with data 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110; in_ready stays 0 during each WRITE cycle; exactly one done.
- Range boundaries:
  - base 60, count 4 -> writes to 60..63, error=0.
  - base 60, count 5 -> no mem_we, done and error=1 at T+1; error stays high until the next start.
- Zero count: count 0 -> done at T+1, error=0, no writes; a full 64-word load from base 0 writes 0..63, and mem_addr never wraps into a 65th write.
- Reset mid-word: rst after 5 bytes of word 2 -> next cycle state IDLE, all outputs 0, no write for the partial word; a fresh load afterwards packs from byte index 0.
- Start while busy: start pulsed during COLLECT with a different base -> ignored; the original sequence completes unchanged.
